// File: rtl/xsim_msg_framer.sv
// xsim_msg_framer: frames a (method, length) descriptor plus its payload
// words into a header beat followed by payload beats for the Xsim
// message-source stage. Over-length descriptors are consumed and flagged.
module xsim_msg_framer #(
  parameter logic [31:0] PORTAL_ID = 32'd0,
  parameter int          MAX_WORDS = 1022
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [15:0] msg_method,
  input  logic [15:0] msg_words,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [31:0] data,
  output logic [31:0] portal,
  output logic        en_beat,
  output logic [31:0] beat,
  output logic        busy,
  output logic        err_overlen,
  output logic [31:0] beat_count
);

  // Header length field is msg_words+1, so the limit must leave room for it.
  localparam logic [15:0] MaxW = 16'(MAX_WORDS);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic        en_beat_q, en_beat_d;
  logic [31:0] beat_q, beat_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;

  // Handshake readies depend on state only, never on the input valids.
  assign msg_ready   = (state_q == IDLE);
  assign data_ready  = (state_q == PAYLOAD);
  assign portal      = PORTAL_ID;
  assign en_beat     = en_beat_q;
  assign beat        = beat_q;
  assign busy        = (state_q != IDLE);
  assign err_overlen = err_q;
  assign beat_count  = cnt_q;

  // Next-state: descriptor/payload acceptance and the registered beat.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    en_beat_d   = 1'b0;
    beat_d      = beat_q;
    err_d       = err_q;
    // Count the beat currently presented downstream.
    cnt_d       = cnt_q + {31'd0, en_beat_q};
    unique case (state_q)
      IDLE: begin
        if (msg_valid) begin
          if (msg_words > MaxW) begin
            // Consumed but dropped; payload draining is the producer's job.
            err_d = 1'b1;
          end else begin
            en_beat_d   = 1'b1;
            beat_d      = {msg_method, msg_words + 16'd1};
            remaining_d = msg_words;
            if (msg_words != 16'd0) state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (data_valid) begin
          en_beat_d   = 1'b1;
          beat_d      = data;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins over any same-cycle handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      remaining_q <= 16'd0;
      en_beat_q   <= 1'b0;
      beat_q      <= 32'd0;
      err_q       <= 1'b0;
      cnt_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      en_beat_q   <= en_beat_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_xsim_msg_framer.sv
// Scoreboard bench for xsim_msg_framer: drivers push {cycle, beat} into a
// queue; a negedge monitor pops and compares whenever en_beat is seen.
module tb_xsim_msg_framer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic [15:0] msg_method = 16'd0;
  logic [15:0] msg_words = 16'd0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [31:0] data = 32'd0;
  logic [31:0] portal;
  logic        en_beat;
  logic [31:0] beat;
  logic        busy;
  logic        err_overlen;
  logic [31:0] beat_count;

  xsim_msg_framer #(.PORTAL_ID(32'd0), .MAX_WORDS(4)) dut (
    .CLK(CLK), .RST(RST),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_method(msg_method), .msg_words(msg_words),
    .data_valid(data_valid), .data_ready(data_ready), .data(data),
    .portal(portal), .en_beat(en_beat), .beat(beat), .busy(busy),
    .err_overlen(err_overlen), .beat_count(beat_count)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  logic [63:0] sbq[$];   // {expected cycle, expected beat}

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every presented beat must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (en_beat) begin
      nvec = nvec + 1;
      if (sbq.size() == 0) begin
        nerr = nerr + 1;
        $display("FAIL beat_unexpected: got beat=%08h at cyc %0d, none expected", beat, cyc);
      end else begin
        logic [63:0] e;
        e = sbq.pop_front();
        if (beat !== e[31:0] || cyc != int'(e[63:32])) begin
          nerr = nerr + 1;
          $display("FAIL beat: got %08h at cyc %0d, expected %08h at cyc %0d",
                   beat, cyc, e[31:0], e[63:32]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Beat accepted at the coming edge is visible at the following negedge.
  task automatic push(input logic [31:0] b);
    sbq.push_back({32'(cyc + 1), b});
  endtask

  // Drive one descriptor for one cycle (called at a negedge).
  task automatic send_msg(input logic [15:0] m, input logic [15:0] w, input logic ok);
    msg_valid = 1'b1; msg_method = m; msg_words = w;
    if (ok) push({m, w + 16'd1});
    @(negedge CLK);
    msg_valid = 1'b0;
  endtask

  // Drive one payload cycle; v=0 is a gap cycle.
  task automatic send_data(input logic [31:0] d, input logic v);
    data_valid = v; data = d;
    if (v) push(d);
    @(negedge CLK);
    data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    // Reset state
    chk("rst_en_beat", 32'(en_beat), 32'd0);
    chk("rst_beat", beat, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_overlen), 32'd0);
    chk("rst_count", beat_count, 32'd0);
    chk("rst_msg_ready", 32'(msg_ready), 32'd1);
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    chk("portal", portal, 32'd0);

    // 3-word message, data always valid
    send_msg(16'h0005, 16'd3, 1'b1);
    chk("m3_busy", 32'(busy), 32'd1);
    send_data(32'hA, 1'b1);
    send_data(32'hB, 1'b1);
    send_data(32'hC, 1'b1);
    chk("m3_busy_drop", 32'(busy), 32'd0);
    idle(1);
    chk("m3_count", beat_count, 32'd4);

    // Back-to-back zero-length messages
    send_msg(16'h0001, 16'd0, 1'b1);
    chk("z1_data_ready", 32'(data_ready), 32'd0);
    send_msg(16'h0002, 16'd0, 1'b1);
    chk("z2_data_ready", 32'(data_ready), 32'd0);
    idle(1);
    chk("z_count", beat_count, 32'd6);

    // Payload with two gap cycles
    send_msg(16'h0007, 16'd2, 1'b1);
    send_data(32'h11, 1'b1);
    send_data(32'h0, 1'b0);
    chk("gap1_en_beat", 32'(en_beat), 32'd0);
    chk("gap1_msg_ready", 32'(msg_ready), 32'd0);
    send_data(32'h0, 1'b0);
    chk("gap2_en_beat", 32'(en_beat), 32'd0);
    chk("gap2_msg_ready", 32'(msg_ready), 32'd0);
    send_data(32'h22, 1'b1);
    idle(1);
    chk("gap_count", beat_count, 32'd9);

    // Over-length rejected, boundary length accepted
    send_msg(16'h0009, 16'd5, 1'b0);
    chk("ovl_err", 32'(err_overlen), 32'd1);
    chk("ovl_en_beat", 32'(en_beat), 32'd0);
    chk("ovl_msg_ready", 32'(msg_ready), 32'd1);
    idle(1);
    chk("ovl_sticky", 32'(err_overlen), 32'd1);
    send_msg(16'h000A, 16'd4, 1'b1);
    for (int i = 0; i < 4; i++) send_data(32'hF00 + 32'(i), 1'b1);
    idle(1);
    chk("max_err_sticky", 32'(err_overlen), 32'd1);
    chk("max_count", beat_count, 32'd14);

    // Reset mid-message; reset beats a same-cycle payload handshake
    send_msg(16'h0005, 16'd3, 1'b1);
    send_data(32'hD0, 1'b1);
    RST = 1'b1; data_valid = 1'b1; data = 32'hD1;
    @(negedge CLK);
    RST = 1'b0; data_valid = 1'b0;
    chk("mr_en_beat", 32'(en_beat), 32'd0);
    chk("mr_msg_ready", 32'(msg_ready), 32'd1);
    chk("mr_count", beat_count, 32'd0);
    chk("mr_err", 32'(err_overlen), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    idle(1);
    chk("mr_quiet", 32'(en_beat), 32'd0);
    send_msg(16'h0003, 16'd1, 1'b1);
    send_data(32'h77, 1'b1);
    idle(1);
    chk("mr_count2", beat_count, 32'd2);

    // beat_count wrap
    force dut.cnt_q = 32'hFFFF_FFFE;
    @(negedge CLK);
    release dut.cnt_q;
    send_msg(16'h0004, 16'd0, 1'b1);
    chk("wrap0", beat_count, 32'hFFFF_FFFE);
    send_msg(16'h0004, 16'd0, 1'b1);
    chk("wrap1", beat_count, 32'hFFFF_FFFF);
    send_msg(16'h0004, 16'd0, 1'b1);
    chk("wrap2", beat_count, 32'h0000_0000);
    idle(1);
    chk("wrap3", beat_count, 32'h0000_0001);

    idle(3);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
